// File: rtl/pc_pkg.sv
// Shared select encodings for the PC / return-address-stack unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD    = 3'd0,
    PC_SEQ     = 3'd1,
    PC_RST_VEC = 3'd2,
    PC_INT_VEC = 3'd3,
    PC_ZERO    = 3'd4,
    PC_BUS_BUF = 3'd5,
    PC_REL     = 3'd6,
    PC_RAS     = 3'd7
  } pc_sel_e;

  typedef enum logic [1:0] {
    OFS_HOLD     = 2'd0,
    OFS_INC      = 2'd1,
    OFS_ZERO     = 2'd2,
    OFS_HOLD_ALT = 2'd3
  } offset_sel_e;

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address stack: pushing onto a full stack overwrites the oldest
// entry, with sticky overflow/underflow flags.
module ras_lifo #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear_flags,
  input  logic [ADDR_W-1:0]        push_data,
  output logic [ADDR_W-1:0]        top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              empty, full, ovf_set, unf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (push && pop && !empty) begin
      mem_d[wr_ptr_q - PTR_W'(1)] = push_data;
    end else if (push) begin
      // Write pointer wraps, so a push when full lands on the oldest slot.
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (full) ovf_set = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q - PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
    end
    ovf_d = ovf_set | (ovf_q & ~clear_flags);
    unf_d = unf_set | (unf_q & ~clear_flags);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign top       = empty ? '0 : mem_q[wr_ptr_q - PTR_W'(1)];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with byte-offset counter, low-byte operand buffer and
// return-address stack.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned OFFSET_W  = 2,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned VEC_W     = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   data_bus,
  input  logic [VEC_W-1:0]             rst_pc_in,
  input  logic [VEC_W-1:0]             int_pc_in,
  input  logic [2:0]                   pc_sel,
  input  logic [1:0]                   offset_sel,
  input  logic                         write_temp_buf,
  input  logic                         ras_push,
  input  logic                         ras_pop,
  input  logic                         clear_flags,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_w_offset,
  output logic [ADDR_W-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [7:0]          tmp_buf_q, tmp_buf_d;
  logic [ADDR_W-1:0]   pc_seq, rst_vec, int_vec, bus_buf, pc_rel;

  assign pc_w_offset = pc_q + ADDR_W'(offset_q);
  assign pc_seq      = pc_w_offset + ADDR_W'(1);
  assign rst_vec     = ADDR_W'({rst_pc_in, 3'b000});
  assign int_vec     = ADDR_W'({1'b1, int_pc_in, 3'b000});
  assign bus_buf     = ADDR_W'({data_bus, tmp_buf_q});
  assign pc_rel      = pc_w_offset + {{(ADDR_W-8){data_bus[7]}}, data_bus};

  always_comb begin
    pc_d = pc_q;
    case (pc_sel_e'(pc_sel))
      PC_HOLD:    pc_d = pc_q;
      PC_SEQ:     pc_d = pc_seq;
      PC_RST_VEC: pc_d = rst_vec;
      PC_INT_VEC: pc_d = int_vec;
      PC_ZERO:    pc_d = '0;
      PC_BUS_BUF: pc_d = bus_buf;
      PC_REL:     pc_d = pc_rel;
      PC_RAS:     pc_d = ras_top;
      default:    pc_d = pc_q;
    endcase

    offset_d = offset_q;
    case (offset_sel_e'(offset_sel))
      OFS_INC:  offset_d = offset_q + OFFSET_W'(1);
      OFS_ZERO: offset_d = '0;
      default:  offset_d = offset_q;
    endcase

    tmp_buf_d = write_temp_buf ? data_bus : tmp_buf_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q      <= '0;
      offset_q  <= '0;
      tmp_buf_q <= '0;
    end else begin
      pc_q      <= pc_d;
      offset_q  <= offset_d;
      tmp_buf_q <= tmp_buf_d;
    end
  end

  assign pc = pc_q;

  ras_lifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push        (ras_push),
    .pop         (ras_pop),
    .clear_flags (clear_flags),
    .push_data   (pc_seq),
    .top         (ras_top),
    .count       (ras_count),
    .overflow    (ras_overflow),
    .underflow   (ras_underflow)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// directed sequences with hand-computed expectations.
module tb_pc_stack_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MASK  = 32'hFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_bus = '0;
  logic [2:0]  rst_pc_in = '0, int_pc_in = '0, pc_sel = '0;
  logic [1:0]  offset_sel = '0;
  logic        write_temp_buf = 1'b0, ras_push = 1'b0, ras_pop = 1'b0, clear_flags = 1'b0;
  logic [15:0] pc, pc_w_offset, ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  pc_stack_unit #(
    .ADDR_W    (16),
    .OFFSET_W  (2),
    .RAS_DEPTH (DEPTH),
    .VEC_W     (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_bus       (data_bus),
    .rst_pc_in      (rst_pc_in),
    .int_pc_in      (int_pc_in),
    .pc_sel         (pc_sel),
    .offset_sel     (offset_sel),
    .write_temp_buf (write_temp_buf),
    .ras_push       (ras_push),
    .ras_pop        (ras_pop),
    .clear_flags    (clear_flags),
    .pc             (pc),
    .pc_w_offset    (pc_w_offset),
    .ras_top        (ras_top),
    .ras_count      (ras_count),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit model_ok = 0;

  int unsigned m_pc, m_off, m_buf;
  int unsigned m_stk[$];
  bit          m_ovf, m_unf;

  function automatic int unsigned m_pwo();
    return (m_pc + m_off) & MASK;
  endfunction

  function automatic int unsigned m_top();
    return (m_stk.size() > 0) ? m_stk[$] : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    int unsigned pwo, pwo1, top, sext, npc;
    bit ovf_ev, unf_ev;
    if (!reset) begin
      m_pc = 0; m_off = 0; m_buf = 0;
      m_stk.delete();
      m_ovf = 0; m_unf = 0;
      model_ok = 1;
    end else begin
      pwo  = m_pwo();
      pwo1 = (pwo + 1) & MASK;
      top  = m_top();
      sext = data_bus[7] ? (32'(data_bus) + 32'hFF00) : 32'(data_bus);
      case (pc_sel)
        3'd0:    npc = m_pc;
        3'd1:    npc = pwo1;
        3'd2:    npc = 32'(rst_pc_in) * 8;
        3'd3:    npc = 64 + 32'(int_pc_in) * 8;
        3'd4:    npc = 0;
        3'd5:    npc = 32'(data_bus) * 256 + m_buf;
        3'd6:    npc = pwo + sext;
        default: npc = top;
      endcase
      m_pc = npc & MASK;
      if (offset_sel == 2'd1)      m_off = (m_off + 1) % 4;
      else if (offset_sel == 2'd2) m_off = 0;
      if (write_temp_buf) m_buf = 32'(data_bus);
      ovf_ev = 0; unf_ev = 0;
      if (ras_push && ras_pop && m_stk.size() > 0) begin
        m_stk[m_stk.size()-1] = pwo1;
      end else if (ras_push) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          ovf_ev = 1;
        end
        m_stk.push_back(pwo1);
      end else if (ras_pop) begin
        if (m_stk.size() == 0) unf_ev = 1;
        else void'(m_stk.pop_back());
      end
      m_ovf = ovf_ev | (m_ovf & !clear_flags);
      m_unf = unf_ev | (m_unf & !clear_flags);
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("pc", 32'(pc), m_pc);
      chk("pc_w_offset", 32'(pc_w_offset), m_pwo());
      chk("ras_top", 32'(ras_top), m_top());
      chk("ras_count", 32'(ras_count), m_stk.size());
      chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    end
  end

  task automatic step(input logic [2:0] ps, input logic [1:0] os, input logic [7:0] d,
                      input logic w, input logic pu, input logic po, input logic cl);
    pc_sel = ps; offset_sel = os; data_bus = d;
    write_temp_buf = w; ras_push = pu; ras_pop = po; clear_flags = cl;
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    step(0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_pwo", 32'(pc_w_offset), 0);
    chk("rst_top", 32'(ras_top), 0);
    chk("rst_count", 32'(ras_count), 0);

    // sequential fetch with offset increment
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("seq1_pc", 32'(pc), 32'h0001);
    chk("seq1_pwo", 32'(pc_w_offset), 32'h0002);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("seq2_pc", 32'(pc), 32'h0003);
    chk("seq2_pwo", 32'(pc_w_offset), 32'h0005);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    chk("seq3_pc", 32'(pc), 32'h0006);
    chk("seq3_pwo", 32'(pc_w_offset), 32'h0009);

    step(0, 2, 8'h34, 1, 0, 0, 0);
    step(5, 0, 8'h12, 0, 0, 0, 0);
    chk("bus_buf_pc", 32'(pc), 32'h1234);

    step(0, 0, 8'h00, 1, 0, 0, 0);
    step(5, 0, 8'h01, 0, 0, 0, 0);
    chk("load100_pc", 32'(pc), 32'h0100);
    step(0, 1, 8'h00, 0, 0, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0, 0);
    chk("off2_pwo", 32'(pc_w_offset), 32'h0102);
    step(6, 0, 8'hFE, 0, 0, 0, 0);
    chk("rel_neg_pc", 32'(pc), 32'h0100);
    step(6, 0, 8'h05, 0, 0, 0, 0);
    chk("rel_pos_pc", 32'(pc), 32'h0107);

    rst_pc_in = 3'd7;
    step(2, 0, 8'h00, 0, 0, 0, 0);
    chk("rst_vec_pc", 32'(pc), 32'h0038);
    int_pc_in = 3'd2;
    step(3, 0, 8'h00, 0, 0, 0, 0);
    chk("int_vec_pc", 32'(pc), 32'h0050);

    step(0, 2, 8'hFF, 1, 0, 0, 0);
    step(5, 0, 8'hFF, 0, 0, 0, 0);
    chk("max_pc", 32'(pc), 32'hFFFF);
    step(1, 0, 8'h00, 0, 0, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h0000);

    // overflow then drain to underflow
    step(0, 2, 8'h10, 1, 0, 0, 0);
    step(5, 0, 8'h00, 0, 0, 0, 0);
    chk("ras_base_pc", 32'(pc), 32'h0010);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 1, 0, 0);
    chk("full_count", 32'(ras_count), 4);
    chk("full_ovf", 32'(ras_overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk("pop_top", 32'(ras_top), 32'h15 - i);
      step(0, 0, 8'h00, 0, 0, 1, 0);
    end
    chk("empty_count", 32'(ras_count), 0);
    chk("empty_top", 32'(ras_top), 0);
    chk("empty_unf", 32'(ras_underflow), 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    chk("unf_set", 32'(ras_underflow), 1);
    chk("unf_top", 32'(ras_top), 0);
    step(7, 0, 8'h00, 0, 0, 0, 0);
    chk("ras_empty_pc", 32'(pc), 0);

    step(0, 0, 8'h00, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ras_overflow), 0);
    chk("clr_unf", 32'(ras_underflow), 0);
    step(1, 0, 8'h00, 0, 1, 0, 0);
    step(1, 0, 8'h00, 0, 1, 0, 0);
    step(0, 0, 8'h00, 0, 1, 1, 0);
    chk("pushpop_count", 32'(ras_count), 2);
    chk("pushpop_top", 32'(ras_top), 32'h0003);
    step(7, 0, 8'h00, 0, 0, 0, 0);
    chk("ras_jump_pc", 32'(pc), 32'h0003);
    reset = 1'b0;
    step(1, 1, 8'h00, 1, 1, 0, 0);
    reset = 1'b1;
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_pwo", 32'(pc_w_offset), 0);
    chk("midrst_top", 32'(ras_top), 0);
    chk("midrst_count", 32'(ras_count), 0);

    for (int i = 0; i < 3000; i++) begin
      rst_pc_in = 3'($urandom);
      int_pc_in = 3'($urandom);
      reset = ($urandom_range(0, 199) != 0);
      step(3'($urandom), 2'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
